// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch datapath and its control FSM.
//   - cmd_e   : control command encodings
//   - state_e : control FSM state encodings
//   - DIGIT_W : width of one BCD digit
//   - LIM9/LIM5 : highest value of a decimal digit and of a base-6 tens digit
package stopwatch_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_START = 2'd1,
    CMD_PAUSE = 2'd2,
    CMD_STOP  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;
  localparam int LIM9    = 9;
  localparam int LIM5    = 5;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit of the stopwatch ripple chain.
//   clk   : rising-edge clock
//   clr   : asynchronous active-low reset
//   clear : synchronous clear, active-high (wins over inc)
//   inc   : advance by one this edge
//   q     : current digit value, 0..MAX
//   co    : carry-out, high when this digit rolls over MAX->0 this edge
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MAX = LIM9
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               clear,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               co
);

  logic [DIGIT_W-1:0] q_q, q_d;
  logic               at_max;

  assign at_max = (q_q == DIGIT_W'(MAX));

  always_comb begin
    q_d = q_q;
    if (clear)    q_d = '0;
    else if (inc) q_d = at_max ? '0 : q_q + DIGIT_W'(1);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q  = q_q;
  assign co = inc && at_max;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base and mm:ss.cc BCD counter.
//   clk        : system clock, rising edge
//   clr        : asynchronous active-low reset
//   rst        : synchronous clear from control FSM, active-low (beats en)
//   en         : count enable from control FSM
//   cs_o/cs_t  : centiseconds ones/tens
//   s_o/s_t    : seconds ones/tens (tens 0..5)
//   m_o/m_t    : minutes ones/tens (tens 0..5)
//   tick       : one-cycle pulse on every accepted count step
//   ovf        : sticky flag set on wrap past 59:59.99
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               rst,
  input  logic               en,
  output logic [DIGIT_W-1:0] cs_o,
  output logic [DIGIT_W-1:0] cs_t,
  output logic [DIGIT_W-1:0] s_o,
  output logic [DIGIT_W-1:0] s_t,
  output logic [DIGIT_W-1:0] m_o,
  output logic [DIGIT_W-1:0] m_t,
  output logic               tick,
  output logic               ovf
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NDIG   = 6;

  logic [PW-1:0] pre_q, pre_d;
  logic          step;
  logic          tick_q;
  logic          ovf_q, ovf_d;

  logic [NDIG-1:0][DIGIT_W-1:0] dig;
  logic [NDIG-1:0]              inc;
  logic [NDIG-1:0]              co;

  // Prescaler: a paused count keeps its partial value so resume continues
  // mid-period instead of restarting the centisecond.
  always_comb begin
    pre_d = pre_q;
    step  = 1'b0;
    if (!rst) begin
      pre_d = '0;
    end else if (en) begin
      if (pre_q == PW'(DIV - 1)) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // co[NDIG-1] is the carry out of the minutes tens digit, i.e. the wrap.
  always_comb begin
    ovf_d = ovf_q;
    if (!rst)              ovf_d = 1'b0;
    else if (co[NDIG-1])   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= step;
      ovf_q  <= ovf_d;
    end
  end

  // Ripple chain: digit 0 steps on the prescaler wrap, each later digit on
  // the carry of the one below. Indices 3 and 5 are the base-6 tens digits.
  assign inc = {co[NDIG-2:0], step};

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam int MAXV = (i == 3 || i == 5) ? LIM5 : LIM9;
    bcd_digit #(.MAX(MAXV)) u_dig (
      .clk   (clk),
      .clr   (clr),
      .clear (!rst),
      .inc   (inc[i]),
      .q     (dig[i]),
      .co    (co[i])
    );
  end

  assign cs_o = dig[0];
  assign cs_t = dig[1];
  assign s_o  = dig[2];
  assign s_t  = dig[3];
  assign m_o  = dig[4];
  assign m_t  = dig[5];
  assign tick = tick_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-base and BCD digit counter for the stopwatch, directly downstream of the stopwatch control FSM. It consumes the FSM's `rst` (active-low synchronous clear) and `en` (count enable). It divides the system clock into a centisecond tick and advances a mm:ss.cc BCD time value that feeds the display driver. An overflow flag marks wrap past 59:59.99.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `TICK_HZ`, 100: count rate; `DIV = CLK_HZ/TICK_HZ`, must be ≥ 2 and an exact integer.
- `clk`  in  1  system clock, rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `rst`  in  1  synchronous clear from control FSM, active-low.
- `en`  in  1  count enable from control FSM, active-high.
- `cs_o`, `cs_t`  out  4 each  centisecond ones/tens (BCD 0–9).
- `s_o`, `s_t`  out  4 each  seconds ones (0–9) / tens (0–5).
- `m_o`, `m_t`  out  4 each  minutes ones (0–9) / tens (0–5).
- `tick`  out  1  one-cycle pulse on each accepted count step.
- `ovf`  out  1  sticky overflow flag.

## Operation
- `clr` low asynchronously forces all outputs to 0 and the prescaler to 0.
- Priority per edge: `rst`==0 > `en`==1 > hold.
  - `rst`==0: prescaler, all digits and `ovf` go to 0; `tick` is 0. This applies regardless of `en`.
  - `rst`==1, `en`==1: prescaler increments. At `DIV-1` it wraps to 0, `tick`=1, and the BCD chain increments by one centisecond.
  - `rst`==1, `en`==0 (pause): prescaler and digits hold. `tick` is 0. The partial prescaler count is retained, so resume continues mid-period.
- BCD chain uses ripple-carry: cs_o 9→0 carries to cs_t, cs_t 9→0 to s_o, s_o 9→0 to s_t, s_t 5→0 to m_o, m_o 9→0 to m_t, m_t 5→0 sets the wrap.
- Wrap: on 59:59.99 plus one step, all digits become 0 and `ovf` is set to 1. `ovf` stays 1 until `rst`==0 or `clr`==0. A further wrap leaves it at 1.
- Digits never hold non-BCD values; each digit resets to 0 on carry-out only.
- The FSM restart sequence (`rst`=0 for one cycle, then `rst`=1/`en`=1) yields 00:00.00. The first tick comes `DIV` cycles after `en` is seen.

## Timing
- All state is registered on `posedge clk`. Outputs come directly from flops, with no combinational paths from inputs to outputs.
- Latency: `en` rising at edge k (first edge sampling `en`=1 from a zero prescaler) puts `tick` and the new digit value at edge k+DIV-1 (DIV accepted cycles). Both change on the same edge.
- `rst` low takes effect on the next edge, so outputs are 0 one cycle later.
- `clr` assertion is asynchronous. Deassertion is assumed synchronized upstream.
- Reset values: every digit 0, `tick` 0, `ovf` 0, prescaler 0.
- Prescaler width: `$clog2(DIV)` bits.

## Structure
- Shared package `stopwatch_pkg` holds:
  - FSM command encodings (`nop`=0, `start`=1, `pause`=2, `stop`=3),
  - state encodings,
  - `DIGIT_W`=4,
  - digit limits `LIM9`=9 and `LIM5`=5.
- Sub-module `bcd_digit` (parameter `MAX`):
  - inputs `clk`, `clr`, `clear`, `inc`;
  - outputs `q[3:0]` and `co` (combinational carry = `inc && q==MAX`).
  - Six instances are chained.
- The prescaler and `ovf` logic stay in the top module.

## Test plan
Run with `CLK_HZ`=10, `TICK_HZ`=1 (`DIV`=10).
- **Reset:** `clr`=0 with `en`=1 → all digits 0, `tick`=0, `ovf`=0; hold 5 cycles with no change.
- **Count:** `clr`=1, `rst`=1, `en`=1 for 10 cycles → single `tick` on the 10th edge, cs_o=1. After 100 cycles → cs_t=1, cs_o=0.
- **Pause:** run 14 cycles (1 tick plus prescaler 4), then `en`=0 for 20 cycles → digits stay 00:00.01 and no tick. Re-enable → next tick after 6 cycles.
- **Clear priority:** at 00:00.37 assert `rst`=0 together with `en`=1 → next edge all digits 0, `ovf`=0, and the prescaler restarts (next tick 10 cycles after `rst`=1).
- **Carry chain:** start at 00:59.99 one cycle before a tick → next tick gives 01:00.00. Start at 09:59.99 → 10:00.00.
- **Overflow:** start at 59:59.99 one cycle before a tick → next tick gives 00:00.00 with `ovf`=1. `ovf` persists through further ticks and clears on `rst`=0. Assert `clr`=0 mid-prescale → immediate asynchronous zeroing of all outputs.
